demux_1_4_seq: RTL and testbench
================================

Name: demux_1_4_seq

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the 4-input select mux in the mux library.
- Accepts one input beat per cycle over a valid/ready handshake.
- Steers each beat, by a 2-bit select, into one of four single-entry output holding registers, each with its own valid/ready handshake.
- Sits between a single producer and four independent consumers. A full channel back-pressures only beats that target it.

Parameters:
- WIDTH, 8, data width of each beat and of each output channel.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts the beat this cycle.
- sel  input  2  destination channel 0..3, sampled with in_data.
- in_data  input  WIDTH  beat payload.
- out_valid  output  4  bit k: channel k holds a beat.
- out_ready  input  4  bit k: consumer k takes the beat this cycle.
- out_data  output  4*WIDTH  channel k payload on bits [k*WIDTH +: WIDTH].
- acc_count  output  CNT_W  total beats accepted since reset.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=4'b0000, out_data=0, acc_count=0.
  - in_ready is low during any cycle with rst=1.
  - A beat in flight at reset is discarded and never appears on any output.
  - Reset mid-operation clears all held beats immediately at that edge.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer on channel k occurs when out_valid[k] && out_ready[k].
- in_ready is combinational: in_ready = !rst && (!out_valid[sel] || out_ready[sel]).
  - A full channel that drains this cycle accepts a new beat in the same cycle (pass-through refill, no bubble).
- Latency: a beat accepted at edge N appears on out_data[sel] with out_valid[sel]=1 immediately after edge N (1 cycle).
- Per-channel state, two states:
  - EMPTY -> FULL on an input transfer with sel==k.
  - FULL -> EMPTY on an output transfer with no new input for k.
  - FULL stays FULL, with the register reloaded, on a simultaneous output transfer and input transfer for k.
  - FULL holds its data stable while out_ready[k]=0.
- Data stability: out_data for channel k changes only on an input transfer to k or on reset.
  - Contents while EMPTY are don't-care but must remain the last value.
- Independence:
  - Channels drain in parallel; several out_ready bits may be high in one cycle.
  - A stalled channel never blocks beats routed elsewhere.
- sel and in_data are don't-care when in_valid=0.
  - The producer must keep sel and in_data stable while in_valid=1 and in_ready=0.
- acc_count increments by 1 per input transfer and wraps 2^CNT_W-1 -> 0 with no flag.

Optional Feature:
- Macro DEMUX_BCAST_EN.
- When defined:
  - Adds input port bcast (1 bit).
  - A beat with bcast=1 is written to all four channels simultaneously.
  - in_ready for a broadcast beat requires every channel to be EMPTY or draining this cycle.
  - acc_count increments by 1 per broadcast beat, not 4.
  - sel is ignored when bcast=1.
- When not defined:
  - No bcast port.
  - Behaviour is exactly unicast as above.

Test Plan:
- Reset release, then in_valid=1, sel=2, in_data=8'hA5, out_ready=4'b0000 -> after 1 edge out_valid=4'b0100, channel 2 data=8'hA5, acc_count=1; other channels stay invalid.
- Channel 2 full, out_ready[2]=0, offer sel=2, data=8'h3C -> in_ready=0 for any number of cycles, channel 2 holds 8'hA5. Then offer sel=1, data=8'h3C -> in_ready=1, channel 1 gets 8'h3C.
- Channel 0 full with 8'h11, out_ready[0]=1, same-cycle input sel=0, data=8'h22 -> in_ready=1, out_valid[0] stays 1, data becomes 8'h22, no empty cycle.
- Back-to-back $random sel/data for 64 beats with random out_ready -> scoreboard shows every beat delivered once, in order per channel, to its sel channel; acc_count=64.
- Assert rst with all four channels full -> next cycle out_valid=4'b0000, acc_count=0. Beat presented during reset never appears.
- (DEMUX_BCAST_EN) bcast=1, data=8'h5A, all channels empty -> all four out_valid set, all data=8'h5A, acc_count+1. Repeat with channel 3 stalled -> in_ready=0 until out_ready[3]=1.

Source files
------------

// File: rtl/demux_1_4_seq.sv
// Registered 1-to-4 demultiplexer with per-channel single-entry holding registers.
// Optional broadcast input enabled by defining DEMUX_BCAST_EN.
module demux_1_4_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   in_data,
`ifdef DEMUX_BCAST_EN
  input  logic               bcast,
`endif
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]   acc_count
);

  localparam int unsigned NCH = 4;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

  ch_state_t        state_q [NCH];
  ch_state_t        state_d [NCH];
  logic [WIDTH-1:0] data_q  [NCH];
  logic [NCH-1:0]   room;
  logic [NCH-1:0]   wr;
  logic             is_bcast;
  logic             xfer;

`ifdef DEMUX_BCAST_EN
  assign is_bcast = bcast;
`else
  assign is_bcast = 1'b0;
`endif

  // A channel can take a beat if it is empty or being drained this cycle
  always_comb begin
    room = '0;
    for (int k = 0; k < NCH; k++) begin
      room[k] = (state_q[k] == CH_EMPTY) || out_ready[k];
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = is_bcast ? (&room) : room[sel];
    end
  end

  assign xfer = in_valid && in_ready;

  always_comb begin
    wr = '0;
    for (int k = 0; k < NCH; k++) begin
      wr[k] = xfer && (is_bcast || (sel == 2'(k)));
    end
  end

  // Per-channel next state: a write wins over a drain (reload without bubble)
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        CH_EMPTY: if (wr[k]) state_d[k] = CH_FULL;
        CH_FULL:  if (!wr[k] && out_ready[k]) state_d[k] = CH_EMPTY;
        default:  state_d[k] = CH_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) state_q[k] <= CH_EMPTY;
    end else begin
      for (int k = 0; k < NCH; k++) state_q[k] <= state_d[k];
    end
  end

  // Payload registers change only on a write to that channel or on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wr[k]) data_q[k] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_count <= '0;
    end else if (xfer) begin
      acc_count <= acc_count + CNT_W'(1);
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      out_valid[k]                  = (state_q[k] == CH_FULL);
      out_data[k*WIDTH +: WIDTH]    = data_q[k];
    end
  end

endmodule

// File: tb/tb_demux_1_4_seq.sv
// Scoreboard bench for demux_1_4_seq: per-channel expected queues fed by the
// stimulus process, drained and compared by an independent monitor process.
module tb_demux_1_4_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   in_data;
  logic               bcast_r;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [CNT_W-1:0]   acc_count;

  demux_1_4_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .in_data   (in_data),
`ifdef DEMUX_BCAST_EN
    .bcast     (bcast_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .acc_count (acc_count)
  );

  always #5 clk = ~clk;

  // Reference model: what each consumer should still receive, in order
  logic [WIDTH-1:0] exp_q [4][$];
  logic [WIDTH-1:0] last_data [4];
  logic [CNT_W-1:0] exp_count;
  int               n_checks = 0;
  int               n_pass   = 0;
  logic             mon_en   = 1'b0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last_data[k] = '0;
    end
    exp_count = '0;
  endtask

  // Monitor: compares whatever the DUT presents against the model
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        for (int k = 0; k < 4; k++) begin
          check("out_valid", k, 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
          if (exp_q[k].size() != 0) begin
            check("out_data", k, 32'(out_data[k*WIDTH +: WIDTH]), 32'(exp_q[k][0]));
            if (out_ready[k]) void'(exp_q[k].pop_front());
          end else begin
            check("hold_data", k, 32'(out_data[k*WIDTH +: WIDTH]), 32'(last_data[k]));
          end
        end
        check("acc_count", 0, 32'(acc_count), 32'(exp_count));
      end
    end
  end

  // One cycle of stimulus; records an accepted beat into the model
  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] ordy, input logic bc, output logic took);
    logic exp_rdy;
    @(negedge clk);
    rst = 1'b0; in_valid = v; sel = s; in_data = d; out_ready = ordy; bcast_r = bc;
    #2;
    if (bc) begin
      exp_rdy = 1'b1;
      for (int k = 0; k < 4; k++)
        if (exp_q[k].size() != 0 && !ordy[k]) exp_rdy = 1'b0;
    end else begin
      exp_rdy = (exp_q[s].size() == 0) || ordy[s];
    end
    check("in_ready", int'(s), 32'(in_ready), 32'(exp_rdy));
    took = v && in_ready;
    if (took) begin
      exp_count = exp_count + 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (bc || (s == 2'(k))) begin
          exp_q[k].push_back(d);
          last_data[k] = d;
        end
      end
    end
  endtask

  // Reset cycles with a beat on offer that must be discarded
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; sel = 2'd3; in_data = 8'hEE; out_ready = 4'b0000; bcast_r = 1'b0;
      #2;
      check("in_ready_rst", i, 32'(in_ready), 32'd0);
      clear_model();
    end
  endtask

  initial begin
    logic             took;
    logic             pending;
    logic [1:0]       rs;
    logic [WIDTH-1:0] rd;
    int               n_acc;
    int               budget;

    rst = 1'b1; in_valid = 1'b0; sel = '0; in_data = '0; out_ready = '0; bcast_r = 1'b0;
    clear_model();
    do_reset(2);
    mon_en = 1'b1;

    // Single beat into channel 2, then let it sit
    drive(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0, took);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, took);

    // Full, stalled channel 2 refuses; channel 1 still accepts
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd2, 8'h3C, 4'b0000, 1'b0, took);
    drive(1'b1, 2'd1, 8'h3C, 4'b0000, 1'b0, took);

    // Pass-through refill of channel 0
    drive(1'b1, 2'd0, 8'h11, 4'b0000, 1'b0, took);
    drive(1'b1, 2'd0, 8'h22, 4'b0001, 1'b0, took);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, took);
    drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, took);

    // Randomized traffic; producer holds sel/data while stalled
    n_acc = 0; budget = 0; pending = 1'b0; rs = '0; rd = '0;
    while (n_acc < 64 && budget < 2000) begin
      if (!pending) begin
        rs = 2'($urandom);
        rd = 8'($urandom);
        pending = 1'b1;
      end
      drive(1'b1, rs, rd, 4'($urandom), 1'b0, took);
      if (took) begin
        pending = 1'b0;
        n_acc++;
      end
      budget++;
    end
    check("rand_beats", 0, 32'(n_acc), 32'd64);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, took);

    // Fill every channel then reset mid-operation
    for (int k = 0; k < 4; k++) drive(1'b1, 2'(k), 8'(8'h40 + k), 4'b0000, 1'b0, took);
    do_reset(1);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, took);

`ifdef DEMUX_BCAST_EN
    // Broadcast into empty channels, then with channel 3 stalled
    drive(1'b1, 2'd1, 8'h5A, 4'b0000, 1'b1, took);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd0, 8'h77, 4'b0111, 1'b1, took);
    drive(1'b1, 2'd0, 8'h77, 4'b1111, 1'b1, took);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, took);
`endif

    for (int k = 0; k < 4; k++) check("drained", k, 32'(exp_q[k].size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
